// File: rtl/booth_mul_sched.sv
// Sequential radix-2 Booth multiplier shared by NREQ requesters via a round-robin scheduler.
// One multiply in flight; one Booth step per clock; results are tagged with the requester index.
module booth_mul_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_m,
    input  logic [NREQ*WIDTH-1:0]   req_q,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_p
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [WIDTH:0]      r_m;
    logic [WIDTH:0]      r_acc;
    logic [WIDTH-1:0]    r_q;
    logic                r_qprev;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_p;

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_gidx;
    logic                w_found;
    logic                w_accept;
    logic [WIDTH-1:0]    w_m_sel;
    logic [WIDTH-1:0]    w_q_sel;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_acc_next;
    logic [WIDTH-1:0]    w_q_next;

    function automatic logic [31:0] rr_idx(input logic [IDW-1:0] base, input int unsigned off);
        return (32'(base) + off) % NREQ;
    endfunction

    // First set request at or after r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[rr_idx(r_ptr, k)]) begin
                w_found                   = 1'b1;
                w_gidx                    = IDW'(rr_idx(r_ptr, k));
                w_grant[rr_idx(r_ptr, k)] = 1'b1;
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found;
    assign w_m_sel  = req_m[32'(w_gidx) * WIDTH +: WIDTH];
    assign w_q_sel  = req_q[32'(w_gidx) * WIDTH +: WIDTH];

    always_comb begin
        case ({r_q[0], r_qprev})
            2'b10:   w_sum = r_acc - r_m;
            2'b01:   w_sum = r_acc + r_m;
            default: w_sum = r_acc;
        endcase
    end

    // Arithmetic shift of {acc, q, q_prev}; q_prev picks up the old q[0].
    assign w_acc_next = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_next   = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_qprev <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m     <= {w_m_sel[WIDTH-1], w_m_sel};
                        r_q     <= w_q_sel;
                        r_id    <= w_gidx;
                        r_acc   <= '0;
                        r_qprev <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_q     <= w_q_next;
                    r_qprev <= r_q[0];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_p     <= {w_acc_next[WIDTH-1:0], w_q_next};
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_ptr   <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (rst_n && r_state == S_IDLE) ? w_grant : '0;
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_id    = r_id;
    assign rsp_p     = r_p;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched: directed vectors, full operand sweep,
// backpressure, reset abort, fairness and randomized traffic against a behavioural model.
module tb_booth_mul_sched;

    localparam int W   = 4;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_m;
    logic [N*W-1:0]     req_q;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [2*W-1:0]     rsp_p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_mul_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_m     (req_m),
        .req_q     (req_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    // Model state
    int           ptr_m;
    bit           busy;
    int           k;
    logic [N-1:0] pend;
    logic [W-1:0] om [N];
    logic [W-1:0] oq [N];
    int           exp_id;
    logic [2*W-1:0] exp_p;
    int           grants [$];

    typedef struct {
        int           id;
        logic [W-1:0] m;
        logic [W-1:0] q;
        logic [2*W-1:0] p;
    } vec_t;
    vec_t tbl [5];

    logic [2*W-1:0] p;
    int             rid, lat, n;
    logic [W-1:0]   mm, qq;
    int             exp_order [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        longint a, b;
        a = longint'($signed(m));
        b = longint'($signed(q));
        return (2*W)'(a * b);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++)
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_m[i*W +: W] = om[i];
            req_q[i*W +: W] = oq[i];
        end
        req_valid = pend;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pend = '0;
        req_valid = '0;
        rsp_ready = 1'b1;
        ptr_m = 0;
        busy = 1'b0;
        k = 0;
        for (int i = 0; i < N; i++) begin
            om[i] = '0;
            oq[i] = '0;
        end
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_p", rsp_p, 0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    // Single-requester transaction; rsp_ready is expected to be high.
    task automatic send(input int id, input logic [W-1:0] m, input logic [W-1:0] q,
                        output logic [2*W-1:0] pr, output int idr, output int latr);
        int cnt;
        req_m[id*W +: W] = m;
        req_q[id*W +: W] = q;
        req_valid = '0;
        req_valid[id] = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!req_ready[id] && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("send_grant", req_ready[id], 1);
        @(posedge clk); #1;
        req_valid = '0;
        latr = 0;
        @(negedge clk);
        while (!rsp_valid && latr < 40) begin
            @(negedge clk);
            latr++;
        end
        pr  = rsp_p;
        idr = int'(rsp_id);
        @(posedge clk); #1;
    endtask

    task automatic engine(input int ntx, input bit full, input logic [N-1:0] mask);
        int ndone, cyc, g;
        bit acc_now, done_now;
        logic [N-1:0] ev;
        ndone = 0;
        cyc = 0;
        while (ndone < ntx) begin
            for (int i = 0; i < N; i++) begin
                if (!mask[i]) pend[i] = 1'b0;
                else if (!pend[i] && (full || $urandom_range(0, 3) == 0)) begin
                    pend[i] = 1'b1;
                    om[i] = W'($urandom);
                    oq[i] = W'($urandom);
                end
            end
            drive_ops();
            rsp_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            acc_now = 1'b0;
            done_now = 1'b0;
            g = busy ? -1 : rr_pick(req_valid, ptr_m);
            ev = (g >= 0) ? (N'(1) << g) : '0;
            chk("onehot", $onehot0(req_ready), 1);
            chk("grant", req_ready, ev);
            chk("rsp_valid", rsp_valid, busy && k >= W);
            if (busy && k >= W) begin
                chk("rsp_id", rsp_id, exp_id);
                chk("rsp_p", rsp_p, exp_p);
                if (rsp_ready) done_now = 1'b1;
            end
            if (g >= 0) begin
                acc_now = 1'b1;
                exp_id = g;
                exp_p = ref_mul(om[g], oq[g]);
            end
            @(posedge clk); #1;
            if (acc_now) begin
                busy = 1'b1;
                k = 0;
                pend[g] = 1'b0;
                grants.push_back(g);
            end else if (busy) k++;
            if (done_now) begin
                busy = 1'b0;
                ptr_m = (exp_id + 1) % N;
                ndone++;
            end
            cyc++;
            if (cyc > ntx * 40 + 100) begin
                chk("engine_timeout", ndone, ntx);
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_m = '0;
        req_q = '0;
        rsp_ready = 1'b1;

        tbl[0] = '{0, 4'h3, 4'hE, 8'hFA};
        tbl[1] = '{1, 4'h8, 4'h8, 8'h40};
        tbl[2] = '{2, 4'h8, 4'h7, 8'hC8};
        tbl[3] = '{3, 4'h7, 4'h7, 8'h31};
        tbl[4] = '{0, 4'h0, 4'h8, 8'h00};
        exp_order = '{0, 1, 2, 3, 0, 2, 3, 0, 2};

        do_reset();

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].id, tbl[i].m, tbl[i].q, p, rid, lat);
            chk($sformatf("tbl%0d_p", i), p, tbl[i].p);
            chk($sformatf("tbl%0d_id", i), rid, tbl[i].id);
            chk($sformatf("tbl%0d_lat", i), lat, W);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                mm = W'(a);
                qq = W'(b);
                n = $urandom_range(0, N - 1);
                send(n, mm, qq, p, rid, lat);
                chk($sformatf("sweep_%0d_%0d_p", a, b), p, ref_mul(mm, qq));
                chk($sformatf("sweep_%0d_%0d_id", a, b), rid, n);
            end
        end

        // Backpressure: -3*5 from requester 2 while 0 and 3 wait
        rsp_ready = 1'b0;
        req_m[2*W +: W] = 4'hD;
        req_q[2*W +: W] = 4'h5;
        req_valid = 4'b0100;
        n = 0;
        @(negedge clk);
        while (!req_ready[2] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_m[0 +: W] = 4'h1;
        req_q[0 +: W] = 4'h1;
        req_m[3*W +: W] = 4'h2;
        req_q[3*W +: W] = 4'h2;
        req_valid = 4'b1001;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", n, W);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_p", rsp_p, 8'hF1);
            chk("bp_hold_id", rsp_id, 2);
            chk("bp_hold_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pre_valid", rsp_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_post_valid", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 4'b1000);
        req_valid = '0;
        @(posedge clk); #1;

        // Reset two cycles into a run, then re-present requests
        req_m[2*W +: W] = 4'h1;
        req_q[2*W +: W] = 4'h1;
        req_valid = 4'b0100;
        n = 0;
        @(negedge clk);
        while (!req_ready[2] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mr_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_m[1*W +: W] = 4'h2;
        req_q[1*W +: W] = 4'h3;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("mr_ready", req_ready, 0);
        chk("mr_valid", rsp_valid, 0);
        chk("mr_id", rsp_id, 0);
        chk("mr_p", rsp_p, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_grant_ptr0", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mr_after_lat", n, W);
        chk("mr_after_id", rsp_id, 1);
        chk("mr_after_p", rsp_p, 8'h06);
        @(posedge clk); #1;

        // Fairness: all held high, then requester 1 drops out
        do_reset();
        grants.delete();
        engine(5, 1'b1, 4'b1111);
        engine(4, 1'b1, 4'b1101);
        chk("fair_count", grants.size(), 9);
        for (int i = 0; i < 9 && i < grants.size(); i++)
            chk($sformatf("fair_order%0d", i), grants[i], exp_order[i]);

        // Randomized traffic
        do_reset();
        engine(1000, 1'b0, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
